// File: rtl/imem_load_controller.sv
// imem_load_controller: sequences loading the instruction memory from a
// word stream, holds the CPU in reset during the load, then hands the IMEM
// read port to the CPU fetch path.
// Optional build macro IMEM_LOAD_CHECKSUM_EN: when defined, checksum is the
// XOR of all words written in the current load; otherwise it is tied to 0.
module imem_load_controller #(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic [31:0]           src_addr,
  input  logic                  src_done,
  output logic                  src_rst,
  input  logic [31:0]           cpu_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_we,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst,
  output logic                  loading,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int unsigned TW  = $clog2(TIMEOUT + 1);
  localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDR_WIDTH:0] WORDS_MAX = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_LOAD, S_DRAIN, S_RUN, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [DCW-1:0]        drain_q, drain_d;
  logic                  src_rst_q, src_rst_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic                  imem_we_q, imem_we_d;
  logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  loading_q, loading_d;
  logic                  load_error_q, load_error_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic                  addr_ok;
  logic                  unused_pc_bits;

  assign addr_ok        = (src_addr[31:ADDR_WIDTH] == '0);
  assign unused_pc_bits = ^{cpu_pc[31:ADDR_WIDTH+2], cpu_pc[1:0]};

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    drain_d      = drain_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    words_d      = words_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE:  if (start) state_d = S_FLUSH;
      S_FLUSH: state_d = S_LOAD;
      S_LOAD: begin
        if (src_valid) begin
          tmo_d = '0;
          if (!addr_ok) begin
            state_d = S_ERROR;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = src_addr[ADDR_WIDTH-1:0];
            imem_wdata_d = src_data;
            if (words_q != WORDS_MAX) words_d = words_q + (ADDR_WIDTH+1)'(1);
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_d = csum_q ^ src_data;
`endif
            if (src_done) state_d = S_DRAIN;
          end
        end else if (src_done) begin
          state_d = S_DRAIN;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      // Only cycles with no write in flight count as drain, so a word
      // accepted together with src_done still gets the full settle time.
      S_DRAIN: begin
        if (!imem_we_q) begin
          if (drain_q == DCW'(DRAIN_CYCLES - 1)) state_d = S_RUN;
          else drain_d = drain_q + DCW'(1);
        end
      end
      S_RUN:   if (start) state_d = S_FLUSH;
      S_ERROR: if (start) state_d = S_FLUSH;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_FLUSH) begin
      words_d = '0;
      tmo_d   = '0;
      drain_d = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_d  = '0;
`endif
    end
    if (state_d == S_RUN) imem_addr_d = cpu_pc[ADDR_WIDTH+1:2];

    src_rst_d    = (state_d == S_FLUSH);
    cpu_rst_d    = (state_d != S_RUN);
    loading_d    = (state_d == S_FLUSH) || (state_d == S_LOAD) || (state_d == S_DRAIN);
    load_error_d = (state_d == S_ERROR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tmo_q        <= '0;
      drain_q      <= '0;
      src_rst_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_we_q    <= 1'b0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      loading_q    <= 1'b0;
      load_error_q <= 1'b0;
      words_q      <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      drain_q      <= drain_d;
      src_rst_q    <= src_rst_d;
      imem_addr_q  <= imem_addr_d;
      imem_we_q    <= imem_we_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      loading_q    <= loading_d;
      load_error_q <= load_error_d;
      words_q      <= words_d;
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  // Running XOR of written words.
  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign src_rst      = src_rst_q;
  assign imem_addr    = imem_addr_q;
  assign imem_we      = imem_we_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign loading      = loading_q;
  assign load_error   = load_error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_load_controller.sv
// Directed, table-driven bench for imem_load_controller.
module tb_imem_load_controller;

  logic        clk = 1'b0;
  logic        rst, start, src_valid, src_done;
  logic [31:0] src_data, src_addr, cpu_pc;
  logic        src_rst, imem_we, cpu_rst, loading, load_error;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata, checksum;
  logic [6:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  imem_load_controller #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .DRAIN_CYCLES(2), .TIMEOUT(1024)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .src_valid(src_valid),
    .src_data(src_data), .src_addr(src_addr), .src_done(src_done),
    .src_rst(src_rst), .cpu_pc(cpu_pc), .imem_addr(imem_addr),
    .imem_we(imem_we), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
    .loading(loading), .load_error(load_error),
    .words_loaded(words_loaded), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, valid, done;
    logic [31:0] addr, data;
    logic        e_we;
    logic [5:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_srst, e_crst, e_load, e_err;
    logic [6:0]  e_words;
    logic [31:0] e_csum;
  } vec_t;

  function automatic vec_t mkv(input logic st, va, dn, input logic [31:0] ad, da,
                               input logic we, input logic [5:0] ea, input logic [31:0] ew,
                               input logic sr, cr, ld, er, input logic [6:0] wl,
                               input logic [31:0] cs);
    vec_t v;
    v.start = st; v.valid = va; v.done = dn; v.addr = ad; v.data = da;
    v.e_we = we; v.e_addr = ea; v.e_wdata = ew; v.e_srst = sr; v.e_crst = cr;
    v.e_load = ld; v.e_err = er; v.e_words = wl; v.e_csum = cs;
    return v;
  endfunction

  function automatic logic [31:0] exp_cs(input logic [31:0] x);
`ifdef IMEM_LOAD_CHECKSUM_EN
    return x;
`else
    return 32'h0 & x;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; src_valid = 1'b0; src_done = 1'b0;
    src_addr = '0; src_data = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_src_rst"}, 32'(src_rst), 32'd0);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_loading"}, 32'(loading), 32'd0);
    chk({tag, "_err"}, 32'(load_error), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    chk({tag, "_csum"}, checksum, 32'd0);
  endtask

  vec_t        tbl [17];
  logic [31:0] xacc;
  logic [31:0] w;
  logic        we_seen;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_pc = '0;
    idle_inputs();
    step(); step();
    chk_reset_vals("reset");

    // Full 28-word load.
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("flush_src_rst", 32'(src_rst), 32'd1);
    chk("flush_loading", 32'(loading), 32'd1);
    chk("flush_cpu_rst", 32'(cpu_rst), 32'd1);
    step();
    chk("load_src_rst", 32'(src_rst), 32'd0);
    xacc = '0;
    for (int i = 0; i < 28; i++) begin
      w = (32'h1000_0001 * 32'(i + 1)) ^ 32'h5A5A_0000;
      src_valid = 1'b1; src_addr = 32'(i); src_data = w;
      step();
      xacc ^= w;
      chk($sformatf("w%0d_we", i), 32'(imem_we), 32'd1);
      chk($sformatf("w%0d_addr", i), 32'(imem_addr), 32'(i));
      chk($sformatf("w%0d_wdata", i), imem_wdata, w);
      chk($sformatf("w%0d_words", i), 32'(words_loaded), 32'(i + 1));
    end
    chk("load_csum", checksum, exp_cs(xacc));
    src_valid = 1'b0; src_done = 1'b1; src_addr = '0; src_data = '0;
    step();
    chk("drain1_we", 32'(imem_we), 32'd0);
    chk("drain1_cpu_rst", 32'(cpu_rst), 32'd1);
    step();
    chk("drain2_cpu_rst", 32'(cpu_rst), 32'd1);
    step();
    src_done = 1'b0;
    chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("run_loading", 32'(loading), 32'd0);
    chk("run_words", 32'(words_loaded), 32'd28);

    cpu_pc = 32'h0000_006C;
    step();
    chk("run_pc6c_addr", 32'(imem_addr), 32'd27);
    cpu_pc = 32'h0000_0100;
    step();
    chk("run_pcwrap_addr", 32'(imem_addr), 32'd0);
    chk("run_we", 32'(imem_we), 32'd0);
    chk("run_csum_hold", checksum, exp_cs(xacc));

    // Restart, bad address, recovery, combined valid+done, restart, duplicates.
    //                st va dn addr   data          we ea  ewdata        sr cr ld er wl csum
    tbl[0]  = mkv(1, 0, 0, 0,     0,            0, 0,  0,            1, 1, 1, 0, 0, 0);
    tbl[1]  = mkv(0, 0, 0, 0,     0,            0, 0,  0,            0, 1, 1, 0, 0, 0);
    tbl[2]  = mkv(0, 1, 0, 5,     32'h1234,     1, 5,  32'h1234,     0, 1, 1, 0, 1, 32'h1234);
    tbl[3]  = mkv(0, 1, 0, 64,    32'hDEAD,     0, 0,  0,            0, 1, 0, 1, 1, 32'h1234);
    tbl[4]  = mkv(0, 1, 0, 6,     32'hBEEF,     0, 0,  0,            0, 1, 0, 1, 1, 32'h1234);
    tbl[5]  = mkv(1, 0, 0, 0,     0,            0, 0,  0,            1, 1, 1, 0, 0, 0);
    tbl[6]  = mkv(0, 0, 0, 0,     0,            0, 0,  0,            0, 1, 1, 0, 0, 0);
    tbl[7]  = mkv(0, 1, 0, 63,    32'h1111_1111,1, 63, 32'h1111_1111,0, 1, 1, 0, 1, 32'h1111_1111);
    tbl[8]  = mkv(0, 1, 1, 27,    32'h2222_2222,1, 27, 32'h2222_2222,0, 1, 1, 0, 2, 32'h3333_3333);
    tbl[9]  = mkv(0, 0, 0, 0,     0,            0, 0,  0,            0, 1, 1, 0, 2, 32'h3333_3333);
    tbl[10] = mkv(0, 0, 0, 0,     0,            0, 0,  0,            0, 1, 1, 0, 2, 32'h3333_3333);
    tbl[11] = mkv(0, 0, 0, 0,     0,            0, 0,  0,            0, 0, 0, 0, 2, 32'h3333_3333);
    tbl[12] = mkv(1, 0, 0, 0,     0,            0, 0,  0,            1, 1, 1, 0, 0, 0);
    tbl[13] = mkv(0, 0, 0, 0,     0,            0, 0,  0,            0, 1, 1, 0, 0, 0);
    tbl[14] = mkv(1, 0, 0, 0,     0,            0, 0,  0,            0, 1, 1, 0, 0, 0);
    tbl[15] = mkv(0, 1, 0, 3,     32'hF0,       1, 3,  32'hF0,       0, 1, 1, 0, 1, 32'hF0);
    tbl[16] = mkv(0, 1, 0, 3,     32'h0F,       1, 3,  32'h0F,       0, 1, 1, 0, 2, 32'hFF);

    cpu_pc = 32'h0000_0040;
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].start; src_valid = tbl[i].valid; src_done = tbl[i].done;
      src_addr = tbl[i].addr; src_data = tbl[i].data;
      step();
      chk($sformatf("t%0d_we", i), 32'(imem_we), 32'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("t%0d_addr", i), 32'(imem_addr), 32'(tbl[i].e_addr));
        chk($sformatf("t%0d_wdata", i), imem_wdata, tbl[i].e_wdata);
      end
      chk($sformatf("t%0d_src_rst", i), 32'(src_rst), 32'(tbl[i].e_srst));
      chk($sformatf("t%0d_cpu_rst", i), 32'(cpu_rst), 32'(tbl[i].e_crst));
      chk($sformatf("t%0d_loading", i), 32'(loading), 32'(tbl[i].e_load));
      chk($sformatf("t%0d_err", i), 32'(load_error), 32'(tbl[i].e_err));
      chk($sformatf("t%0d_words", i), 32'(words_loaded), 32'(tbl[i].e_words));
      chk($sformatf("t%0d_csum", i), checksum, exp_cs(tbl[i].e_csum));
    end
    idle_inputs();

    // Reset on the 10th word of a burst, with a simultaneous start.
    for (int i = 0; i < 9; i++) begin
      src_valid = 1'b1; src_addr = 32'(10 + i); src_data = 32'hA000_0000 + 32'(i);
      step();
    end
    chk("pre_rst_words", 32'(words_loaded), 32'd11);
    rst = 1'b1; start = 1'b1; src_addr = 32'd19; src_data = 32'hA000_0009;
    step();
    chk_reset_vals("midrst");
    rst = 1'b0; start = 1'b0; src_addr = 32'd5;
    step();
    chk("postrst_we", 32'(imem_we), 32'd0);
    chk("postrst_loading", 32'(loading), 32'd0);
    chk("postrst_src_rst", 32'(src_rst), 32'd0);
    idle_inputs();
    step();

    // Source stall: error exactly TIMEOUT cycles into LOAD.
    start = 1'b1;
    step();
    start = 1'b0;
    we_seen = 1'b0;
    for (int k = 1; k <= 1024; k++) begin
      step();
      if (imem_we) we_seen = 1'b1;
    end
    chk("stall_err_early", 32'(load_error), 32'd0);
    step();
    chk("stall_err", 32'(load_error), 32'd1);
    chk("stall_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("stall_no_we", 32'(we_seen | imem_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_load_controller.md
Name: imem_load_controller

Overview:
- Sequences loading of the processor instruction memory from the instruction stream source (assembler or emulator).
- Stream interface: valid, 32-bit word, 32-bit word address, done.
- Holds the CPU in reset while loading, owns the IMEM port during the load, then hands the IMEM read address to the CPU fetch path and releases the CPU.
- Supports restart (reload) on request, and error detection for bad addresses and a stalled source.

Parameters:
- ADDR_WIDTH, 6, IMEM word-address width (depth 2**ADDR_WIDTH).
- DATA_WIDTH, 32, instruction width.
- DRAIN_CYCLES, 2, idle cycles after the last write before CPU release (BRAM write settle / output register).
- TIMEOUT, 1024, maximum cycles in LOAD without src_valid before error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: begin or restart a load.
- src_valid  in  1  stream word valid.
- src_data  in  DATA_WIDTH  stream word.
- src_addr  in  32  stream word address.
- src_done  in  1  source has sent all words (level).
- src_rst  out  1  restart pulse to the stream source.
- cpu_pc  in  32  CPU fetch byte address.
- imem_addr  out  ADDR_WIDTH  IMEM address.
- imem_we  out  1  IMEM write enable.
- imem_wdata  out  DATA_WIDTH  IMEM write data.
- cpu_rst  out  1  CPU reset.
- loading  out  1  high in FLUSH/LOAD/DRAIN.
- load_error  out  1  high in ERROR.
- words_loaded  out  ADDR_WIDTH+1  count of words written this load.
- checksum  out  DATA_WIDTH  see Optional Feature.

Behaviour:
- Reset values:
  - state IDLE; cpu_rst=1; src_rst=0; imem_we=0; imem_addr=0; imem_wdata=0.
  - loading=0; load_error=0; words_loaded=0; checksum=0; timeout counter=0.
- All outputs are registered.
- States:
  - IDLE: cpu_rst=1; stream ignored. On start, go to FLUSH.
  - FLUSH: exactly 1 cycle. src_rst=1; clears words_loaded, checksum and the timeout counter. Next state LOAD.
  - LOAD:
    - On src_valid with src_addr < 2**ADDR_WIDTH: the next cycle has imem_we=1, imem_addr=src_addr[ADDR_WIDTH-1:0], imem_wdata=src_data; words_loaded increments. Write latency is 1 cycle.
    - On src_valid with src_addr >= 2**ADDR_WIDTH: no write; go to ERROR.
    - src_done with src_valid=0: go to DRAIN.
    - src_valid and src_done in the same cycle: the word is written, then go to DRAIN.
    - The timeout counter clears on every src_valid and increments otherwise. Reaching TIMEOUT goes to ERROR.
    - start in LOAD is ignored.
    - words_loaded saturates at 2**ADDR_WIDTH.
  - DRAIN: imem_we=0, cpu_rst=1 for DRAIN_CYCLES cycles, then go to RUN.
  - RUN:
    - cpu_rst=0; imem_we=0.
    - imem_addr = cpu_pc[ADDR_WIDTH+1:2] (word index; upper PC bits ignored, so the address wraps).
    - start goes to FLUSH, and cpu_rst=1 is asserted in the FLUSH cycle.
  - ERROR:
    - load_error=1; cpu_rst=1; imem_we=0; stream ignored.
    - Left only via start (to FLUSH) or rst.
- imem_we is never high outside the cycle following an accepted LOAD word.
- Duplicate addresses overwrite: the last write wins, and each one still counts in words_loaded.
- rst mid-LOAD: state returns to IDLE on the next edge; any in-flight write is dropped (imem_we=0).
- start and rst in the same cycle: rst wins.

Optional Feature:
- Macro: IMEM_LOAD_CHECKSUM_EN.
- Defined: checksum = XOR of every word written during the current load, updated in the same cycle as imem_we. It is cleared in FLUSH and held stable in RUN and ERROR.
- Undefined: checksum is tied to 0 and no accumulator logic is built.

Test Plan:
- Reset, start, 28 words at addresses 0..27 then src_done:
  - src_rst high exactly 1 cycle after start.
  - 28 imem_we pulses, each 1 cycle after its src_valid.
  - words_loaded=28; cpu_rst falls 2 cycles after the last write.
  - With the macro, checksum = XOR of the 28 words.
- RUN with cpu_pc=0x0000006C: imem_addr=27. With cpu_pc=0x00000100: imem_addr=0 (wrap).
- Word with src_addr=64 during LOAD: no write; load_error=1 next cycle; cpu_rst stays 1. A following start recovers through FLUSH to LOAD.
- Source stalls for 1024 cycles in LOAD: ERROR entered; no imem_we after the stall begins.
- src_valid and src_done together on word 27 (address 27): word 27 is written, then DRAIN 2 cycles, then RUN. A start in RUN re-asserts cpu_rst and pulses src_rst.
- rst asserted on the 10th LOAD word: IDLE on the next cycle; imem_we=0; outputs at reset values; a start pulse in the same cycle as rst is ignored.
